// File: rtl/alu_pkg.sv
// alu_pkg: ALU opcode encoding, RISC-V funct3 codes and sequencer FSM states.
package alu_pkg;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_SRL = 4'b1000;
    localparam logic [3:0] OP_SLL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;
    localparam logic [3:0] OP_XOR = 4'b1101;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;
endpackage

// File: rtl/alu_funct_decoder.sv
// alu_funct_decoder: maps {funct3, funct7b5, is_imm} to the 4-bit ALU opcode and an illegal flag.
module alu_funct_decoder
    import alu_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       is_imm,
    output logic [3:0] opcode,
    output logic       illegal
);
    always_comb begin
        opcode  = OP_ADD;
        illegal = 1'b0;
        case (funct3)
            F3_ADD:  opcode = (funct7b5 && !is_imm) ? OP_SUB : OP_ADD;
            F3_SLL:  begin
                opcode  = OP_SLL;
                illegal = funct7b5;
            end
            F3_SLT:  opcode = OP_SLT;
            F3_SLTU: illegal = 1'b1;
            F3_XOR:  opcode = OP_XOR;
            F3_SR:   opcode = funct7b5 ? OP_SRA : OP_SRL;
            F3_OR:   opcode = OP_OR;
            default: opcode = OP_AND;
        endcase
    end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: decodes a command, drives a combinational ALU, waits ALU_LATENCY cycles
// and returns the captured result on a valid/ready response channel.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int ALU_LATENCY = 1,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           cmd_funct3,
    input  logic                 cmd_funct7b5,
    input  logic                 cmd_is_imm,
    input  logic [WIDTH-1:0]     cmd_a,
    input  logic [WIDTH-1:0]     cmd_b,
    output logic [WIDTH-1:0]     alu_op1,
    output logic [WIDTH-1:0]     alu_op2,
    output logic [3:0]           alu_opcode,
    input  logic [WIDTH-1:0]     alu_result,
    input  logic                 alu_zero,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WIDTH-1:0]     rsp_result,
    output logic                 rsp_zero,
    output logic                 rsp_illegal,
    output logic [CNT_WIDTH-1:0] op_count
);
    state_t     state, state_nx;
    logic [3:0] settle;
    logic [3:0] dec_opcode;
    logic       dec_illegal;

    alu_funct_decoder u_dec (
        .funct3   (cmd_funct3),
        .funct7b5 (cmd_funct7b5),
        .is_imm   (cmd_is_imm),
        .opcode   (dec_opcode),
        .illegal  (dec_illegal)
    );

    assign cmd_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (cmd_valid) state_nx = dec_illegal ? ST_RESP : ST_EXEC;
            ST_EXEC: if (settle == 4'd0) state_nx = ST_RESP;
            ST_RESP: if (rsp_ready) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            settle      <= 4'd0;
            alu_op1     <= '0;
            alu_op2     <= '0;
            alu_opcode  <= OP_ADD;
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
            rsp_illegal <= 1'b0;
            op_count    <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && cmd_valid) begin
                if (dec_illegal) begin
                    rsp_result  <= '0;
                    rsp_zero    <= 1'b0;
                    rsp_illegal <= 1'b1;
                end else begin
                    alu_op1    <= cmd_a;
                    alu_op2    <= cmd_b;
                    alu_opcode <= dec_opcode;
                    settle     <= 4'(ALU_LATENCY - 1);
                end
            end
            // ALU operands have been stable for ALU_LATENCY cycles when the counter reaches zero
            if (state == ST_EXEC) begin
                if (settle == 4'd0) begin
                    rsp_result  <= alu_result;
                    rsp_zero    <= alu_zero;
                    rsp_illegal <= 1'b0;
                end else begin
                    settle <= settle - 4'd1;
                end
            end
            if (state == ST_RESP && rsp_ready) op_count <= op_count + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed plus randomized commands against a behavioural reference model,
// with a behavioural combinational ALU attached to the sequencer.
module tb_alu_cmd_sequencer;
    localparam int W  = 32;
    localparam int L  = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_funct3 = '0;
    logic          cmd_funct7b5 = 1'b0;
    logic          cmd_is_imm = 1'b0;
    logic [W-1:0]  cmd_a = '0;
    logic [W-1:0]  cmd_b = '0;
    logic [W-1:0]  alu_op1, alu_op2, alu_result;
    logic [3:0]    alu_opcode;
    logic          alu_zero;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [W-1:0]  rsp_result;
    logic          rsp_zero, rsp_illegal;
    logic [CW-1:0] op_count;

    int         n_chk = 0;
    int         n_pass = 0;
    int         exp_cnt = 0;
    logic [3:0] exp_code = 4'b0010;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.WIDTH(W), .ALU_LATENCY(L), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_funct3(cmd_funct3), .cmd_funct7b5(cmd_funct7b5), .cmd_is_imm(cmd_is_imm),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_opcode(alu_opcode), .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal), .op_count(op_count)
    );

    // Stand-in combinational ALU using the team opcode encoding
    always_comb begin
        case (alu_opcode)
            4'b0000: alu_result = alu_op1 & alu_op2;
            4'b0001: alu_result = alu_op1 | alu_op2;
            4'b0010: alu_result = alu_op1 + alu_op2;
            4'b0110: alu_result = alu_op1 - alu_op2;
            4'b0111: alu_result = W'($signed(alu_op1) < $signed(alu_op2));
            4'b1000: alu_result = alu_op1 >> alu_op2[4:0];
            4'b1001: alu_result = alu_op1 << alu_op2[4:0];
            4'b1010: alu_result = W'($signed(alu_op1) >>> alu_op2[4:0]);
            4'b1101: alu_result = alu_op1 ^ alu_op2;
            default: alu_result = 32'hDEAD_BEEF;
        endcase
        alu_zero = (alu_result == '0);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // {illegal, result} of the instruction as the ISA defines it
    function automatic logic [32:0] ref_op(input logic [2:0] f3, input logic b5, input logic imm,
                                           input logic [31:0] a, input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (f3)
            3'd0:    return {1'b0, (b5 && !imm) ? a - b : a + b};
            3'd1:    return b5 ? {1'b1, 32'd0} : {1'b0, a << sh};
            3'd2:    return {1'b0, 32'($signed(a) < $signed(b))};
            3'd3:    return {1'b1, 32'd0};
            3'd4:    return {1'b0, a ^ b};
            3'd5:    return {1'b0, b5 ? 32'($signed(a) >>> sh) : a >> sh};
            3'd6:    return {1'b0, a | b};
            default: return {1'b0, a & b};
        endcase
    endfunction

    function automatic logic [3:0] ref_code(input logic [2:0] f3, input logic b5, input logic imm);
        case (f3)
            3'd0:    return (b5 && !imm) ? 4'b0110 : 4'b0010;
            3'd1:    return 4'b1001;
            3'd2:    return 4'b0111;
            3'd4:    return 4'b1101;
            3'd5:    return b5 ? 4'b1010 : 4'b1000;
            3'd6:    return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic run(input logic [2:0] f3, input logic b5, input logic imm,
                       input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [32:0] r;
        int          cyc;
        r = ref_op(f3, b5, imm, a, b);
        if (!r[32]) exp_code = ref_code(f3, b5, imm);
        @(negedge clk);
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_funct3 = f3; cmd_funct7b5 = b5; cmd_is_imm = imm; cmd_a = a; cmd_b = b;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_funct3 = 3'($urandom); cmd_a = $urandom; cmd_b = $urandom;
        cyc = 1;
        while (!rsp_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", cyc, r[32] ? 1 : L + 1);
        chk("alu_opcode", alu_opcode, exp_code);
        if (!r[32]) begin
            chk("alu_op1", alu_op1, a);
            chk("alu_op2", alu_op2, b);
        end
        chk("rsp_result", rsp_result, r[31:0]);
        chk("rsp_zero", rsp_zero, !r[32] && r[31:0] == 0);
        chk("rsp_illegal", rsp_illegal, r[32]);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            cmd_valid = 1'($urandom); cmd_funct3 = 3'($urandom); cmd_a = $urandom;
            @(posedge clk); #1;
            chk("hold_valid", rsp_valid, 1);
            chk("hold_result", rsp_result, r[31:0]);
            chk("hold_illegal", rsp_illegal, r[32]);
            chk("hold_cmd_ready", cmd_ready, 0);
            chk("hold_count", op_count, exp_cnt);
        end
        @(negedge clk);
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        exp_cnt = (exp_cnt + 1) % (1 << CW);
        chk("op_count", op_count, exp_cnt);
        chk("rsp_released", rsp_valid, 0);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_op1"}, alu_op1, 0);
        chk({tag, "_op2"}, alu_op2, 0);
        chk({tag, "_opcode"}, alu_opcode, 4'b0010);
        chk({tag, "_result"}, rsp_result, 0);
        chk({tag, "_zero"}, rsp_zero, 0);
        chk({tag, "_illegal"}, rsp_illegal, 0);
        chk({tag, "_count"}, op_count, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        logic        imm;
        #12;
        chk_reset_values("reset");
        @(negedge clk); rst_n = 1'b1;

        run(3'b000, 1'b1, 1'b0, 32'd10, 32'd3, 0);
        run(3'b000, 1'b1, 1'b1, 32'd5, 32'hFFFF_FFFB, 0);
        run(3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'd4, 1);
        run(3'b101, 1'b0, 1'b0, 32'h8000_0000, 32'd4, 0);
        run(3'b011, 1'b0, 1'b0, 32'd1, 32'd2, 0);
        run(3'b001, 1'b1, 1'b0, 32'd1, 32'd2, 0);
        run(3'b010, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 5);
        run(3'b001, 1'b0, 1'b1, 32'h0000_0003, 32'd31, 0);

        // reset while the command is still settling
        @(negedge clk);
        cmd_valid = 1'b1; cmd_funct3 = 3'b100; cmd_funct7b5 = 1'b0; cmd_is_imm = 1'b0;
        cmd_a = 32'h1234_5678; cmd_b = 32'h0F0F_0F0F;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk_reset_values("mid_exec_reset");
        exp_cnt = 0;
        exp_code = 4'b0010;
        @(negedge clk); rst_n = 1'b1;
        repeat (L + 2) @(posedge clk);
        #1;
        chk("no_dropped_rsp", rsp_valid, 0);
        chk("count_after_reset", op_count, 0);

        for (int n = 0; n < 17; n++) begin
            imm = 1'($urandom);
            a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            b = imm ? 32'($signed(12'($urandom))) : ($urandom_range(0, 3) == 0 ? a : $urandom);
            run(3'($urandom), 1'($urandom), imm, a, b, $urandom_range(0, 3));
        end
        chk("count_wrap", op_count, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
